md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same A/B operands (rs/rt after forwarding) and owns the architectural HI/LO registers.
- Drives a stall request to the hazard unit while an operation is in flight.
- HI/LO feed the EX result mux for MFHI/MFLO; that mux is outside this block.

Parameters:
- MUL_LAT, 4, cycles from accepted MULT/MULTU/MADD/MSUB to HI/LO update (must be ≥1).
- DIV_LAT, 10, cycles from accepted DIV/DIVU to HI/LO update (must be ≥1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  op request valid this cycle (EX stage holds a mult/div/mt instruction).
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- A  in  32  rs operand.
- B  in  32  rt operand.
- flush  in  1  cancels any in-flight op (exception/branch squash).
- busy  out  1  registered; an operation is in flight.
- stall_req  out  1  combinational: busy | (start & op∉{4,5} & ~flush).
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (edge with reset=1): hi=0, lo=0, busy=0, internal counter=0, in-flight op discarded. reset overrides start and flush.
- States: IDLE and RUN; busy=1 exactly in RUN.
- Acceptance: start sampled only in IDLE with flush=0. In RUN, start is ignored; the hazard unit must hold the instruction via stall_req.
- MTHI/MTLO (op 4/5): accepted in IDLE; hi<=A or lo<=A at the same edge; stays IDLE; busy never rises.
- Mult/div accept: at accept edge, latch A, B and op, and load counter = MUL_LAT or DIV_LAT. Go to RUN.
- RUN countdown: counter decrements each edge. On the edge where counter reaches 0, write hi/lo and go to IDLE. busy is high for exactly LAT cycles.
- Back-to-back: a new start is accepted on the first cycle busy=0.
- MULT: {hi,lo} = signed(A)*signed(B), 64-bit.
- MULTU: {hi,lo} = A*B, unsigned 64-bit.
- MADD: {hi,lo} = {hi,lo} + signed(A)*signed(B), mod 2^64.
- MSUB: {hi,lo} = {hi,lo} − signed(A)*signed(B), mod 2^64.
- MADD/MSUB source: the {hi,lo} value used is the one at completion; it is unchanged during RUN.
- DIVU: lo = A/B, hi = A%B, unsigned.
- DIV: signed, quotient truncates toward zero, remainder has the sign of A.
- DIV overflow: A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (DIV/DIVU, B=0): lo=0xFFFFFFFF, hi=A. Completes in DIV_LAT like any other divide.
- Datapath implementation is free (iterative or combinational+delay); only the latency and results are fixed.
- Operand capture: A/B changes after acceptance do not affect the result.
- flush=1 in RUN: next edge → IDLE, busy=0, hi/lo unchanged.
- flush=1 on the completing edge: write suppressed.
- flush=1 with start in IDLE: nothing accepted, MTHI/MTLO included.
- hi/lo are read directly; there is no bypass of a same-cycle MTHI/MTLO write.

Test Plan:
1. Reset, then start MULT with A=0xFFFFFFFE (−2), B=3 → busy high 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_req=1 on the start cycle.
2. MULTU with A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 4 cycles.
3. DIV with A=−7 (0xFFFFFFF9), B=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with A=7, B=0 → lo=0xFFFFFFFF, hi=7.
4. MTHI A=0x12345678, then MTLO A=1, then MADD A=2, B=3 → hi=0x12345678, lo=7. MTHI/MTLO never raise busy.
5. Start DIV, assert flush on cycle 3 → busy=0 next cycle, hi/lo keep prior values. Separately, reset on cycle 5 of a DIV → hi=lo=0, busy=0.
6. start pulses while busy with changing A/B → ignored, result reflects the first operands. A new MULT presented the cycle busy falls is accepted immediately.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit in the EX stage.
// Owns the architectural HI/LO registers. MTHI/MTLO write in one cycle.
// Multiplies and divides latch their operands, stay busy for a fixed latency,
// then write HI/LO. A flush cancels any in-flight operation.
module md_unit #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        flush,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;
   localparam logic [2:0] OpMadd  = 3'd6;
   localparam logic [2:0] OpMsub  = 3'd7;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]     r_a, r_b;
   logic [2:0]      r_op;
   logic [31:0]     r_hi, r_lo;

   logic            w_is_mt;
   logic            w_is_div;
   logic            w_accept;
   logic            w_done;
   logic            w_mt_wr;

   // Datapath wires
   logic [63:0]     w_prod_s;
   logic [63:0]     w_prod_u;
   logic [63:0]     w_acc;
   logic [31:0]     w_a_mag, w_b_mag, w_b_safe, w_b_mag_safe;
   logic [31:0]     w_q_mag, w_r_mag;
   logic [31:0]     w_q_s, w_r_s, w_q_u, w_r_u;
   logic [63:0]     w_res;

   assign w_is_mt  = (op == OpMthi) || (op == OpMtlo);
   assign w_is_div = (op == OpDiv) || (op == OpDivu);

   // Next-state and countdown control
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_mt_wr     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start && !flush) begin
               if (w_is_mt) begin
                  w_mt_wr = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_state_nxt = StRun;
                  w_cnt_nxt   = w_is_div ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
               end
            end
         end
         StRun: begin
            if (flush) begin
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
            end else if (r_cnt <= CntW'(1)) begin
               // Counter reaches zero on this edge: commit the result.
               w_done      = 1'b1;
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - CntW'(1);
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and operand capture registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= op;
         end
      end
   end

   // Multiply, accumulate and divide results from the latched operands
   always_comb begin
      // Sign-extended operands give the correct low 64 bits of the signed product.
      w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
      w_prod_u = {32'd0, r_a} * {32'd0, r_b};
      w_acc    = {r_hi, r_lo};

      // Signed divide on magnitudes, then restore signs; this also yields the
      // architectural 0x80000000 / -1 overflow result without special handling.
      w_a_mag      = r_a[31] ? (32'd0 - r_a) : r_a;
      w_b_mag      = r_b[31] ? (32'd0 - r_b) : r_b;
      w_b_mag_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
      w_b_safe     = (r_b == 32'd0) ? 32'd1 : r_b;
      w_q_mag      = w_a_mag / w_b_mag_safe;
      w_r_mag      = w_a_mag % w_b_mag_safe;
      w_q_s        = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
      w_r_s        = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
      w_q_u        = r_a / w_b_safe;
      w_r_u        = r_a % w_b_safe;

      w_res = w_acc;
      case (r_op)
         OpMult:  w_res = w_prod_s;
         OpMultu: w_res = w_prod_u;
         OpMadd:  w_res = w_acc + w_prod_s;
         OpMsub:  w_res = w_acc - w_prod_s;
         OpDiv:   w_res = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_r_s, w_q_s};
         OpDivu:  w_res = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_r_u, w_q_u};
         default: w_res = w_acc;
      endcase
   end

   // HI/LO architectural registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_done) begin
         r_hi <= w_res[63:32];
         r_lo <= w_res[31:0];
      end else if (w_mt_wr) begin
         if (op == OpMthi) begin
            r_hi <= A;
         end else begin
            r_lo <= A;
         end
      end
   end

   assign busy      = (r_state == StRun);
   assign stall_req = busy | (start & ~w_is_mt & ~flush);
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. Expected HI/LO values are pushed
// when an op is driven and popped when the DUT finishes it.
module tb_md_unit;

   localparam int unsigned MulLat = 4;
   localparam int unsigned DivLat = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        flush;
   logic        busy, stall_req;
   logic [31:0] hi, lo;

   md_unit #(
      .MUL_LAT(MulLat),
      .DIV_LAT(DivLat)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .flush    (flush),
      .busy     (busy),
      .stall_req(stall_req),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] sb_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference model written against the architectural definitions.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          q, r;
      longint unsigned uq, ur;
      logic [63:0]     res;
      case (o)
         3'd0: res = sa * sb;
         3'd1: res = ua * ub;
         3'd2: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               uq  = ua / ub;
               ur  = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
         3'd4: res = {a, acc[31:0]};
         3'd5: res = {acc[63:32], a};
         3'd6: res = acc + (sa * sb);
         default: res = acc - (sa * sb);
      endcase
      return res;
   endfunction

   // Called just after a negedge; returns just after the negedge where busy is low.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit junk, input string tag);
      bit          is_mt = (o == 3'd4) || (o == 3'd5);
      int unsigned lat   = (o == 3'd2 || o == 3'd3) ? DivLat : MulLat;
      int unsigned n     = 0;
      logic [63:0] exp, got;
      start = 1'b1; op = o; A = a; B = b;
      #1;
      check({tag, " stall_req"}, {63'd0, stall_req}, {63'd0, !is_mt});
      sb_q.push_back(model(o, a, b, {m_hi, m_lo}));
      @(negedge clk);
      start = 1'b0;
      if (is_mt) begin
         check({tag, " busy"}, {63'd0, busy}, 64'd0);
      end else begin
         while (busy && n < 50) begin
            n++;
            if (junk) begin
               start = 1'b1;
               op    = 3'($urandom);
               A     = $urandom;
               B     = $urandom;
            end
            @(negedge clk);
         end
         start = 1'b0;
         check({tag, " busy cycles"}, 64'(n), 64'(lat));
      end
      exp = sb_q.pop_front();
      got = {hi, lo};
      check({tag, " hi/lo"}, got, exp);
      {m_hi, m_lo} = exp;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset hi/lo", {hi, lo}, 64'd0);
      check("reset stall_req", {63'd0, stall_req}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Multiplies
      do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult -2*3");
      check("mult -2*3 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max");
      check("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // Divides, including divide-by-zero and overflow
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
      check("div -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(3'd3, 32'd7, 32'd0, 1'b0, "divu 7/0");
      check("divu 7/0 const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
      do_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, "div -16/0");
      do_op(3'd3, 32'hFFFF_FFF9, 32'd10, 1'b0, "divu big");
      do_op(3'd2, 32'd100, 32'hFFFF_FFF9, 1'b0, "div 100/-7");

      // MTHI/MTLO and accumulate
      do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, "mthi");
      do_op(3'd5, 32'd1, 32'd0, 1'b0, "mtlo");
      do_op(3'd6, 32'd2, 32'd3, 1'b0, "madd");
      check("madd const", {hi, lo}, 64'h1234_5678_0000_0007);
      do_op(3'd7, 32'hFFFF_FFFF, 32'd9, 1'b0, "msub");
      do_op(3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "madd wrap");

      // Flush on run cycle 3 of a divide
      start = 1'b1; op = 3'd2; A = 32'd50; B = 32'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", {63'd0, busy}, 64'd0);
      check("flush hi/lo", {hi, lo}, {m_hi, m_lo});
      repeat (DivLat) @(negedge clk);
      check("flush hi/lo later", {hi, lo}, {m_hi, m_lo});

      // Flush with start in IDLE: nothing accepted
      start = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF; flush = 1'b1;
      #1;
      check("flush mthi stall_req", {63'd0, stall_req}, 64'd0);
      @(negedge clk);
      check("flush mthi hi/lo", {hi, lo}, {m_hi, m_lo});
      op = 3'd0;
      #1;
      check("flush mult stall_req", {63'd0, stall_req}, 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush mult busy", {63'd0, busy}, 64'd0);

      // Start ignored while busy; back-to-back accept as busy falls
      do_op(3'd0, 32'd1000, 32'hFFFF_FFFD, 1'b1, "mult junk");
      do_op(3'd2, 32'd12345, 32'd67, 1'b1, "div junk");
      do_op(3'd0, 32'd7, 32'd6, 1'b0, "mult b2b");

      // Reset on cycle 5 of a divide
      start = 1'b1; op = 3'd2; A = 32'd99; B = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset busy", {63'd0, busy}, 64'd0);
      check("midreset hi/lo", {hi, lo}, 64'd0);
      m_hi = '0; m_lo = '0;
      repeat (DivLat) @(negedge clk);
      check("midreset hi/lo later", {hi, lo}, 64'd0);

      check("scoreboard empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
